// File: rtl/knap_eval_seq.sv
// knap_eval_seq: sequential knapsack candidate evaluator.
// Item tables and limits are writable at runtime; each candidate mask is
// accumulated one item per cycle with saturating totals, and the best
// feasible candidate since reset or clear is tracked.
//
//   state | meaning
//   IDLE  | ready for a candidate, config writes accepted
//   EVAL  | stepping through items 0..N_ITEMS-1, then one cycle to register results
//   DONE  | result held on res_* until consumed
module knap_eval_seq #(
  parameter int N_ITEMS = 5,
  parameter int VW      = 10,
  parameter int SUM_W   = 16,
  localparam int AW     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
  localparam int CW     = $clog2(N_ITEMS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [SUM_W-1:0]   cfg_data,
  input  logic               cand_valid,
  output logic               cand_ready,
  input  logic [N_ITEMS-1:0] cand_mask,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SUM_W-1:0]   res_value,
  output logic [SUM_W-1:0]   res_weight,
  output logic               res_ok,
  input  logic               clear_best,
  output logic               best_found,
  output logic [SUM_W-1:0]   best_value,
  output logic [N_ITEMS-1:0] best_mask
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t             state, state_nxt;
  logic [VW-1:0]      value_tab  [N_ITEMS];
  logic [VW-1:0]      weight_tab [N_ITEMS];
  logic [SUM_W-1:0]   min_value, max_weight;
  logic [N_ITEMS-1:0] mask_q;
  logic [CW-1:0]      idx;
  logic [SUM_W-1:0]   value_acc, weight_acc;
  logic [VW-1:0]      cur_val, cur_wt;
  logic               cur_sel;
  logic               last_step, ok_now, best_upd, accept;

  if (SUM_W > VW) begin : g_unused_hi
    logic unused_cfg_hi;
    assign unused_cfg_hi = ^cfg_data[SUM_W-1:VW];
  end

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  assign accept    = (state == IDLE) && cand_valid;
  assign last_step = (idx == CW'(N_ITEMS));
  assign ok_now    = (value_acc >= min_value) && (weight_acc <= max_weight);
  assign best_upd  = (state == EVAL) && last_step && ok_now &&
                     (!best_found || (value_acc > best_value));

  // Select the table entries and mask bit for the item currently being processed.
  always_comb begin
    cur_val = '0;
    cur_wt  = '0;
    cur_sel = 1'b0;
    for (int j = 0; j < N_ITEMS; j++) begin
      if (idx == CW'(j)) begin
        cur_val = value_tab[j];
        cur_wt  = weight_tab[j];
        cur_sel = mask_q[j];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cand_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        cand_ready = 1'b1;
        if (cand_valid) state_nxt = EVAL;
      end
      EVAL: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config register file; writes land only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < N_ITEMS; j++) begin
        value_tab[j]  <= '0;
        weight_tab[j] <= '0;
      end
      min_value  <= '0;
      max_weight <= '0;
    end else if (cfg_we && (state == IDLE)) begin
      case (cfg_sel)
        2'd0: for (int j = 0; j < N_ITEMS; j++)
                if (cfg_addr == AW'(j)) value_tab[j] <= cfg_data[VW-1:0];
        2'd1: for (int j = 0; j < N_ITEMS; j++)
                if (cfg_addr == AW'(j)) weight_tab[j] <= cfg_data[VW-1:0];
        2'd2: min_value  <= cfg_data;
        default: max_weight <= cfg_data;
      endcase
    end
  end

  // Accumulation datapath and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q     <= '0;
      idx        <= '0;
      value_acc  <= '0;
      weight_acc <= '0;
      res_value  <= '0;
      res_weight <= '0;
      res_ok     <= 1'b1;
    end else begin
      if (accept) begin
        mask_q     <= cand_mask;
        idx        <= '0;
        value_acc  <= '0;
        weight_acc <= '0;
      end else if (state == EVAL) begin
        if (!last_step) begin
          if (cur_sel) begin
            value_acc  <= sat_add(value_acc, SUM_W'(cur_val));
            weight_acc <= sat_add(weight_acc, SUM_W'(cur_wt));
          end
          idx <= idx + 1'b1;
        end else begin
          res_value  <= value_acc;
          res_weight <= weight_acc;
          res_ok     <= ok_now;
        end
      end
    end
  end

  // Best-candidate tracker; clear has priority over an update.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_best) begin
      best_found <= 1'b0;
      best_value <= '0;
      best_mask  <= '0;
    end else if (best_upd) begin
      best_found <= 1'b1;
      best_value <= value_acc;
      best_mask  <= mask_q;
    end
  end

endmodule

// File: tb/tb_knap_eval_seq.sv
// Testbench for knap_eval_seq: directed scenarios plus randomized candidates
// checked against a plain-arithmetic knapsack model.
module tb_knap_eval_seq;
  localparam int N  = 5;
  localparam int VW = 10;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [2:0]    cfg_addr;
  logic [SW-1:0] cfg_data;
  logic          cand_valid, cand_ready;
  logic [N-1:0]  cand_mask;
  logic          res_valid, res_ready, res_ok;
  logic [SW-1:0] res_value, res_weight;
  logic          clear_best, best_found;
  logic [SW-1:0] best_value;
  logic [N-1:0]  best_mask;

  // Narrow instance for saturation
  logic          s_cfg_we;
  logic [1:0]    s_cfg_sel;
  logic [2:0]    s_cfg_addr;
  logic [3:0]    s_cfg_data;
  logic          s_cand_valid, s_cand_ready;
  logic [N-1:0]  s_cand_mask;
  logic          s_res_valid, s_res_ok, s_best_found;
  logic [3:0]    s_res_value, s_res_weight, s_best_value;
  logic [N-1:0]  s_best_mask;

  always #5 clk = ~clk;

  knap_eval_seq #(.N_ITEMS(N), .VW(VW), .SUM_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .cand_mask(cand_mask), .res_valid(res_valid),
    .res_ready(res_ready), .res_value(res_value), .res_weight(res_weight),
    .res_ok(res_ok), .clear_best(clear_best), .best_found(best_found),
    .best_value(best_value), .best_mask(best_mask));

  knap_eval_seq #(.N_ITEMS(N), .VW(4), .SUM_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_we(s_cfg_we), .cfg_sel(s_cfg_sel),
    .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data), .cand_valid(s_cand_valid),
    .cand_ready(s_cand_ready), .cand_mask(s_cand_mask), .res_valid(s_res_valid),
    .res_ready(1'b0), .res_value(s_res_value), .res_weight(s_res_weight),
    .res_ok(s_res_ok), .clear_best(1'b0), .best_found(s_best_found),
    .best_value(s_best_value), .best_mask(s_best_mask));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          vtab [N];
  int          wtab [N];
  int          min_v, max_w;
  bit          m_found;
  int          m_best;
  logic [N-1:0] m_mask;

  function automatic int model_total(input logic [N-1:0] m, input bit use_wt, input int width);
    longint t = 0;
    longint lim = (longint'(1) << width) - 1;
    for (int j = 0; j < N; j++)
      if (m[j]) t += use_wt ? wtab[j] : vtab[j];
    if (t > lim) t = lim;
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin vtab[j] = 0; wtab[j] = 0; end
    min_v = 0; max_w = 0;
    m_found = 0; m_best = 0; m_mask = '0;
  endtask

  task automatic cfg_w(input int sel, input int addr, input int data, input bit upd);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_addr = 3'(addr); cfg_data = 16'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    if (upd) begin
      case (sel)
        0: vtab[addr] = data & 1023;
        1: wtab[addr] = data & 1023;
        2: min_v = data & 65535;
        default: max_w = data & 65535;
      endcase
    end
  endtask

  task automatic load_test_set();
    int vv [N] = '{4, 2, 2, 1, 10};
    int ww [N] = '{12, 1, 2, 1, 4};
    for (int j = 0; j < N; j++) begin
      cfg_w(0, j, vv[j], 1);
      cfg_w(1, j, ww[j], 1);
    end
    cfg_w(2, 0, 15, 1);
    cfg_w(3, 0, 16, 1);
  endtask

  // Offer a candidate, wait for its result and check totals, latency and best tracker.
  task automatic start_cand(input logic [N-1:0] m, input string tag);
    int lat, ev, ew;
    bit eo;
    n_checks++;
    if (cand_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s cand_ready before accept: got %b want 1", tag, cand_ready);
    end
    cand_mask = m; cand_valid = 1'b1;
    @(negedge clk);
    cand_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ev = model_total(m, 0, SW);
    ew = model_total(m, 1, SW);
    eo = (ev >= min_v) && (ew <= max_w);
    if (eo && (!m_found || ev > m_best)) begin
      m_found = 1; m_best = ev; m_mask = m;
    end
    n_checks++;
    if (lat != N + 1) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, N + 1);
    end
    n_checks++;
    if (res_value !== 16'(ev) || res_weight !== 16'(ew) || res_ok !== eo) begin
      n_fail++;
      $display("FAIL %s result: got v=%0d w=%0d ok=%b want v=%0d w=%0d ok=%b",
               tag, res_value, res_weight, res_ok, ev, ew, eo);
    end
    n_checks++;
    if (best_found !== m_found || best_value !== 16'(m_best) || best_mask !== m_mask) begin
      n_fail++;
      $display("FAIL %s best: got f=%b v=%0d m=%b want f=%b v=%0d m=%b",
               tag, best_found, best_value, best_mask, m_found, m_best, m_mask);
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (cand_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s after consume: got ready=%b valid=%b want 1 0", tag, cand_ready, res_valid);
    end
  endtask

  task automatic run_cand(input logic [N-1:0] m, input string tag);
    start_cand(m, tag);
    consume(tag);
  endtask

  task automatic pulse_clear();
    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    m_found = 0; m_best = 0; m_mask = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_checks++;
    if (cand_ready !== 1'b1 || res_valid !== 1'b0 || res_value !== '0 || res_weight !== '0 ||
        res_ok !== 1'b1 || best_found !== 1'b0 || best_value !== '0 || best_mask !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b v=%0d w=%0d ok=%b bf=%b bv=%0d bm=%b want 1 0 0 0 1 0 0 0",
               cand_ready, res_valid, res_value, res_weight, res_ok, best_found, best_value, best_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_test_set();
    start_cand(5'b11110, "mask_11110");
    n_checks++;
    if (res_value !== 16'd15 || res_weight !== 16'd8 || res_ok !== 1'b1 ||
        best_value !== 16'd15 || best_mask !== 5'b11110) begin
      n_fail++;
      $display("FAIL basic_const: got %0d/%0d ok=%b best=%0d/%b want 15/8 ok=1 best=15/11110",
               res_value, res_weight, res_ok, best_value, best_mask);
    end
    consume("mask_11110");
    start_cand(5'b11111, "mask_11111");
    n_checks++;
    if (res_value !== 16'd19 || res_weight !== 16'd20 || res_ok !== 1'b0) begin
      n_fail++; $display("FAIL all_const: got %0d/%0d ok=%b want 19/20 ok=0", res_value, res_weight, res_ok);
    end
    consume("mask_11111");
    run_cand(5'b10001, "mask_10001");
  endtask

  task automatic test_stall();
    start_cand(5'b11110, "stall");
    for (int k = 0; k < 10; k++) begin
      if (k == 3) cfg_w(0, 0, 9, 0);
      else @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_value !== 16'd15 || res_weight !== 16'd8 || cand_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: got vld=%b v=%0d w=%0d rdy=%b want 1 15 8 0",
                 k, res_valid, res_value, res_weight, cand_ready);
      end
    end
    consume("stall");
    start_cand(5'b00001, "dropped_write");
    n_checks++;
    if (res_value !== 16'd4) begin
      n_fail++; $display("FAIL dropped_write: got %0d want 4", res_value);
    end
    consume("dropped_write");
  endtask

  task automatic test_best_tracker();
    cfg_w(2, 0, 10, 1);
    run_cand(5'b11110, "best_a");
    run_cand(5'b10110, "best_b");
    run_cand(5'b11100, "best_c");
    n_checks++;
    if (best_value !== 16'd15 || best_mask !== 5'b11110) begin
      n_fail++; $display("FAIL best_keep: got %0d/%b want 15/11110", best_value, best_mask);
    end
    pulse_clear();
    n_checks++;
    if (best_found !== 1'b0 || best_value !== '0 || best_mask !== '0) begin
      n_fail++; $display("FAIL clear_best: got f=%b v=%0d m=%b want 0 0 0", best_found, best_value, best_mask);
    end
    run_cand(5'b10110, "after_clear");
    n_checks++;
    if (best_value !== 16'd14 || best_mask !== 5'b10110) begin
      n_fail++; $display("FAIL best_after_clear: got %0d/%b want 14/10110", best_value, best_mask);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < N; j++) begin
      cfg_w(0, j, int'($urandom_range(0, 1023)), 1);
      cfg_w(1, j, int'($urandom_range(0, 1023)), 1);
    end
    cfg_w(2, 0, int'($urandom_range(0, 2500)), 1);
    cfg_w(3, 0, int'($urandom_range(0, 3000)), 1);
    pulse_clear();
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) cfg_w(int'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                                           int'($urandom_range(0, 1023)), 1);
      if ($urandom_range(0, 9) == 0) pulse_clear();
      run_cand(5'($urandom), "random");
    end
  endtask

  task automatic test_saturation();
    for (int j = 0; j < N; j++) begin
      s_cfg_we = 1'b1; s_cfg_sel = 2'd0; s_cfg_addr = 3'(j); s_cfg_data = 4'd10;
      @(negedge clk);
    end
    s_cfg_sel = 2'd3; s_cfg_addr = '0; s_cfg_data = 4'd15;
    @(negedge clk);
    s_cfg_we = 1'b0;
    s_cand_mask = 5'b11111; s_cand_valid = 1'b1;
    @(negedge clk);
    s_cand_valid = 1'b0;
    for (int k = 0; k < 20 && s_res_valid !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (s_res_valid !== 1'b1 || s_res_value !== 4'd15 || s_res_weight !== 4'd0 || s_res_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation: got vld=%b v=%0d w=%0d ok=%b want 1 15 0 1",
               s_res_valid, s_res_value, s_res_weight, s_res_ok);
    end
  endtask

  task automatic test_reset_mid_eval();
    cand_mask = 5'b11111; cand_valid = 1'b1;
    @(negedge clk);
    cand_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_checks++;
    if (cand_ready !== 1'b1 || res_valid !== 1'b0 || res_value !== '0 || best_found !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_eval_reset: got rdy=%b vld=%b v=%0d bf=%b want 1 0 0 0",
               cand_ready, res_valid, res_value, best_found);
    end
    start_cand(5'b11111, "post_reset");
    n_checks++;
    if (res_value !== '0 || res_weight !== '0 || res_ok !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_zero: got %0d/%0d ok=%b want 0/0 ok=1", res_value, res_weight, res_ok);
    end
    consume("post_reset");
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    cand_valid = 1'b0; cand_mask = '0; res_ready = 1'b0; clear_best = 1'b0;
    s_cfg_we = 1'b0; s_cfg_sel = '0; s_cfg_addr = '0; s_cfg_data = '0;
    s_cand_valid = 1'b0; s_cand_mask = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_best_tracker();
    test_random();
    test_saturation();
    test_reset_mid_eval();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
